food_spawn_ctrl: RTL
====================

# food_spawn_ctrl

Sequences the cake coordinate generator and publishes a legal food position for the snake game. On game start or a food-eaten pulse, it triggers the generator and latches the candidate coordinate. It range-checks the candidate and scans the snake body memory for overlap. On a hit it retries; on a miss it commits the position to the renderer and collision logic. It sits between the game FSM, the cake generator, and the snake segment RAM.

## Interface
Parameters:
- MAX_LEN, 64: maximum snake segments; seg_addr width is clog2(MAX_LEN).
- GEN_LAT, 2: cycles from a gen_drive pulse to a stable gen_x/gen_y; range 1..15.
- MAX_RETRY, 15: rejected candidates tolerated before declaring failure; range 1..255.
- X_MAX, 39: largest legal grid x (inclusive).
- Y_MAX, 29: largest legal grid y (inclusive).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  game-start pulse; begins a spawn and clears fail.
- eat  in  1  food-eaten pulse; begins a spawn.
- snake_len  in  7  current segment count; 0 means no body to scan.
- gen_drive  out  1  one-cycle request to the cake generator.
- gen_x, gen_y  in  12 each  generator candidate coordinate.
- seg_addr  out  clog2(MAX_LEN)  segment RAM read address.
- seg_x, seg_y  in  12 each  segment coordinate; registered read, valid the cycle after seg_addr.
- food_x, food_y  out  12 each  committed food position.
- food_valid  out  1  food_x/food_y hold a legal, committed position.
- busy  out  1  a spawn is in progress.
- fail  out  1  sticky; set when the retry limit is exhausted.

## Operation
- States: IDLE, GEN, WAIT, SCAN, COMMIT.
- IDLE:
  - start or eat high -> GEN.
  - The retry counter clears on entry from IDLE.
  - food_valid drops on the clock edge that accepts the trigger.
- GEN: gen_drive=1 for exactly this cycle -> WAIT.
- WAIT:
  - Lasts GEN_LAT cycles.
  - On the last cycle, gen_x/gen_y are latched into cand_x/cand_y.
  - -> SCAN.
- SCAN (range check):
  - A candidate is rejected before any read if cand_x > X_MAX or cand_y > Y_MAX.
  - A rejected candidate spends one SCAN cycle, then follows the retry path.
- SCAN (body scan):
  - The effective length is L = min(snake_len, MAX_LEN), latched on SCAN entry.
  - seg_addr steps 0..L-1, one per cycle.
  - Each returned segment is compared one cycle after its address.
  - The scan aborts on the first hit.
  - The total is L+1 cycles when there is no hit.
  - If L = 0, SCAN lasts 1 cycle with no hit.
- Retry path:
  - On a hit or range reject, the retry counter increments.
  - If counter < MAX_RETRY -> GEN.
  - Otherwise set fail=1, leave food_valid=0, and go to IDLE.
- COMMIT:
  - food_x/food_y <= cand_x/cand_y and food_valid <= 1 -> IDLE.
- busy = (state != IDLE).
- fail clears only on an accepted start or on reset.
- eat while busy is ignored: it is neither queued nor counted.
- start while busy aborts the current spawn and re-enters GEN next cycle.
  - It clears the retry counter and fail; food_valid stays 0.
- start and eat high together are treated as start.
- Coordinate compare is exact 12-bit equality on both axes.

## Timing
- Reset values:
  - Outputs: gen_drive=0, seg_addr=0, food_x=0, food_y=0, food_valid=0, busy=0, fail=0.
  - Internal: state=IDLE, retry counter=0.
- Cycle numbering: a trigger sampled at edge 0 gives cycle 1 = GEN (gen_drive high).
- WAIT occupies cycles 2..1+GEN_LAT.
- SCAN occupies cycles 2+GEN_LAT..2+GEN_LAT+L.
- COMMIT is cycle 3+GEN_LAT+L; food_valid is high from cycle 4+GEN_LAT+L.
  - Defaults with L=3: food_valid rises at cycle 9.
- Each rejected attempt adds 1+GEN_LAT+(cycles spent in SCAN).
- All outputs are registered; there are no combinational input-to-output paths.
- Async reset mid-operation forces the reset values immediately; any partial spawn is discarded.
- snake_len changes during SCAN are ignored, because L is latched.

## Test plan
- Reset then idle: rst_n low then high, no triggers -> all outputs 0 for 20 cycles; gen_drive never pulses.
- Clean spawn:
  - Stimulus: eat pulse; len=3; body (5,5),(6,5),(7,5); generator returns (10,12).
  - Required: one gen_drive pulse in cycle 1; seg_addr 0,1,2; food=(10,12); food_valid high at cycle 9.
- Collision retry:
  - Stimulus: same body; first candidate (6,5), second (20,3).
  - Required: two gen_drive pulses; scan aborts at address 1; food=(20,3); fail=0.
- Range reject: candidate (40,0) then (0,29) -> no seg_addr activity on the first attempt; food=(0,29).
- Exhaustion: the generator always returns (5,5); MAX_RETRY=15.
  - Required: exactly 15 gen_drive pulses; fail=1; food_valid=0; busy=0.
  - A subsequent start clears fail.
- Overlapping triggers:
  - Stimulus: eat during SCAN.
  - Required: the eat is ignored (no extra gen_drive).
  - Stimulus: start during SCAN.
  - Required: the scan aborts, gen_drive pulses the next cycle, and the retry count restarts from 0.

Source files
------------

// File: rtl/food_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : food_spawn_ctrl
// Desc   : Requests cake candidates, rejects out-of-range or body-overlapping
//          ones with bounded retries, and publishes the committed food position.
// Rev    : 1.0  initial release
// ============================================================================
module food_spawn_ctrl #(
   parameter int MAX_LEN   = 64,
   parameter int GEN_LAT   = 2,
   parameter int MAX_RETRY = 15,
   parameter int X_MAX     = 39,
   parameter int Y_MAX     = 29
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       eat,
   input  logic [6:0]                 snake_len,
   output logic                       gen_drive,
   input  logic [11:0]                gen_x,
   input  logic [11:0]                gen_y,
   output logic [$clog2(MAX_LEN)-1:0] seg_addr,
   input  logic [11:0]                seg_x,
   input  logic [11:0]                seg_y,
   output logic [11:0]                food_x,
   output logic [11:0]                food_y,
   output logic                       food_valid,
   output logic                       busy,
   output logic                       fail
);

   localparam int c_addr_w = $clog2(MAX_LEN);
   localparam int c_len_w  = c_addr_w + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GEN    = 3'd1,
      WAIT   = 3'd2,
      SCAN   = 3'd3,
      COMMIT = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_wait;
   logic [7:0]           r_retry;
   logic [c_len_w-1:0]   r_len;
   logic [c_len_w-1:0]   r_idx;
   logic [11:0]          r_cand_x;
   logic [11:0]          r_cand_y;

   logic [c_len_w-1:0]   w_len_eff;
   logic [c_len_w-1:0]   w_idx_inc;
   logic [8:0]           w_retry_inc;
   logic                 w_range_bad;
   logic                 w_hit;
   logic                 w_wait_done;
   logic                 w_reject;
   logic                 w_exhaust;
   logic                 w_clear_retry;

   assign busy = (r_state != IDLE);

   always_comb begin
      w_len_eff     = ({25'd0, snake_len} > 32'(MAX_LEN)) ? c_len_w'(MAX_LEN)
                                                          : c_len_w'(snake_len);
      w_idx_inc     = r_idx + c_len_w'(1);
      w_retry_inc   = {1'b0, r_retry} + 9'd1;
      w_range_bad   = (r_cand_x > 12'(X_MAX)) || (r_cand_y > 12'(Y_MAX));
      // index k compares the segment addressed in the previous cycle (k-1)
      w_hit         = (r_idx != '0) && (seg_x == r_cand_x) && (seg_y == r_cand_y);
      w_wait_done   = (r_wait == 4'(GEN_LAT - 1));
      w_clear_retry = start || ((r_state == IDLE) && eat);
      w_next        = r_state;
      w_reject      = 1'b0;
      w_exhaust     = 1'b0;

      if (start) begin
         w_next = GEN;
      end else begin
         case (r_state)
            IDLE:    if (eat) w_next = GEN;
            GEN:     w_next = WAIT;
            WAIT:    if (w_wait_done) w_next = SCAN;
            SCAN: begin
               if ((r_idx == '0) && w_range_bad) begin
                  w_reject = 1'b1;
               end else if (w_hit) begin
                  w_reject = 1'b1;
               end else if (r_idx == r_len) begin
                  w_next = COMMIT;
               end
               if (w_reject) begin
                  if (w_retry_inc < 9'(MAX_RETRY)) begin
                     w_next = GEN;
                  end else begin
                     w_next    = IDLE;
                     w_exhaust = 1'b1;
                  end
               end
            end
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_drive  <= 1'b0;
         seg_addr   <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         fail       <= 1'b0;
         r_wait     <= '0;
         r_retry    <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_cand_x   <= '0;
         r_cand_y   <= '0;
      end else begin
         gen_drive <= (w_next == GEN);
         r_wait    <= (r_state == WAIT) ? r_wait + 4'd1 : 4'd0;

         if (w_clear_retry) begin
            r_retry <= '0;
         end else if (w_reject) begin
            r_retry <= w_retry_inc[7:0];
         end

         if ((r_state == WAIT) && w_wait_done) begin
            r_cand_x <= gen_x;
            r_cand_y <= gen_y;
         end

         // length is frozen for the whole scan
         if ((w_next == SCAN) && (r_state != SCAN)) begin
            r_len <= w_len_eff;
            r_idx <= '0;
         end else if (r_state == SCAN) begin
            r_idx <= w_idx_inc;
         end

         if ((r_state == SCAN) && (w_next == SCAN)) begin
            if (w_idx_inc < r_len) seg_addr <= c_addr_w'(w_idx_inc);
         end else begin
            seg_addr <= '0;
         end

         if (w_clear_retry) begin
            food_valid <= 1'b0;
         end else if (r_state == COMMIT) begin
            food_x     <= r_cand_x;
            food_y     <= r_cand_y;
            food_valid <= 1'b1;
         end

         if (start) begin
            fail <= 1'b0;
         end else if (w_exhaust) begin
            fail <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
